// File: rtl/machine_trap_unit.sv
// machine_trap_unit: M-mode trap/CSR unit; trap arbitration, stall-safe commit; HOLY_TRAP_SYNC_IRQ_EN adds 2-flop irq synchronizers
module machine_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        exception,
    input  logic [30:0] exception_cause,
    input  logic        m_ret,
    input  logic        csr_write_enable,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_func3,
    input  logic [31:0] csr_wdata,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic        irq_ext,
    output logic [31:0] csr_rdata,
    output logic        trap,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state_q, state_d;
    logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, hold_pc_q, hold_pc_d, hold_cause_q, hold_cause_d;
    logic [31:0] mip, mstatus, pend, cause, wval, trap_pc, trap_cause;
    logic        idle, irq_req, trap_req, commit_trap, commit_mret, commit_csr;

`ifdef HOLY_TRAP_SYNC_IRQ_EN
    logic [2:0] irq_s1_q, irq_s2_q;
    // two-flop synchronizer for {ext, timer, soft}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= {irq_ext, irq_timer, irq_soft};
            irq_s2_q <= irq_s1_q;
        end
    end
    assign mip = {20'b0, irq_s2_q[2], 3'b0, irq_s2_q[1], 3'b0, irq_s2_q[0], 3'b0};
`else
    assign mip = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
`endif

    assign mstatus  = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
    assign pend     = mie_q & mip;
    assign irq_req  = mie_bit_q & (|pend);
    assign cause    = exception ? {1'b0, exception_cause} :
                      pend[11]  ? 32'h8000_000B :
                      pend[3]   ? 32'h8000_0003 : 32'h8000_0007;
    assign trap_req = exception | irq_req;
    assign idle     = (state_q == IDLE);
    assign trap     = idle & trap_req;
    // a held trap commits on the first unstalled cycle, ignoring anything new
    assign commit_trap = !stall & (idle ? trap_req : 1'b1);
    assign trap_pc     = idle ? pc : hold_pc_q;
    assign trap_cause  = idle ? cause : hold_cause_q;
    assign commit_mret = idle & !stall & !trap_req & m_ret;
    assign commit_csr  = idle & !stall & !trap_req & !m_ret & csr_write_enable & (csr_func3 inside {3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111});
    assign wval = (csr_func3 inside {3'b001, 3'b101}) ? csr_wdata :
                  (csr_func3 inside {3'b010, 3'b110}) ? (csr_rdata | csr_wdata) : (csr_rdata & ~csr_wdata);
    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

    // CSR read mux, returns the pre-write value
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = mstatus;
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = mip;
            12'hF14: csr_rdata = HART_ID;
            default: csr_rdata = '0;
        endcase
    end

    // next state: trap commit beats MRET beats CSR write
    always_comb begin
        state_d      = state_q;
        hold_pc_d    = hold_pc_q;
        hold_cause_d = hold_cause_q;
        mie_bit_d    = mie_bit_q;
        mpie_d       = mpie_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        if (idle && trap_req && stall) begin
            state_d      = PENDING;
            hold_pc_d    = pc;
            hold_cause_d = cause;
        end else if (!idle && !stall) begin
            state_d = IDLE;
        end
        if (commit_trap) begin
            mepc_d    = trap_pc & ~32'd3;
            mcause_d  = trap_cause;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (commit_mret) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (commit_csr) begin
            case (csr_addr)
                12'h300: begin
                    mie_bit_d = wval[3];
                    mpie_d    = wval[7];
                end
                12'h304: mie_d      = wval & 32'h0000_0888;
                12'h305: mtvec_d    = wval & ~32'd3;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval & ~32'd3;
                12'h342: mcause_d   = wval;
                default: ;
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_pc_q    <= '0;
            hold_cause_q <= '0;
            mie_bit_q    <= 1'b0;
            mpie_q       <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET & ~32'd3;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_pc_q    <= hold_pc_d;
            hold_cause_q <= hold_cause_d;
            mie_bit_q    <= mie_bit_d;
            mpie_q       <= mpie_d;
            mie_q        <= mie_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
        end
    end
endmodule

// File: tb/tb_machine_trap_unit.sv
// tb_machine_trap_unit: directed and randomized checks of machine_trap_unit against a behavioural model
module tb_machine_trap_unit;
    logic        clk = 0, rst_n = 0, stall = 0, exception = 0, m_ret = 0, csr_we = 0;
    logic        irq_timer = 0, irq_soft = 0, irq_ext = 0;
    logic [31:0] pc = 0, csr_wdata = 0;
    logic [30:0] exception_cause = 0;
    logic [11:0] csr_addr = 0;
    logic [2:0]  csr_func3 = 0;
    logic [31:0] csr_rdata, mtvec_o, mepc_o;
    logic        trap;
    int          errors = 0, checks = 0;

    bit          m_mie_b, m_mpie, m_pend;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch, m_hpc, m_hcause;

    machine_trap_unit #(.MTVEC_RESET(32'h0000_1237), .HART_ID(32'd5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .exception(exception),
        .exception_cause(exception_cause), .m_ret(m_ret), .csr_write_enable(csr_we),
        .csr_addr(csr_addr), .csr_func3(csr_func3), .csr_wdata(csr_wdata),
        .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_ext(irq_ext),
        .csr_rdata(csr_rdata), .trap(trap), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
    );

    always #5 clk = ~clk;

    function automatic bit m_irq();
        return m_mie_b && ((irq_ext && m_mie[11]) || (irq_soft && m_mie[3]) || (irq_timer && m_mie[7]));
    endfunction

    function automatic logic [31:0] m_cause();
        if (exception) return {1'b0, exception_cause};
        if (irq_ext && m_mie[11]) return 32'h8000_000B;
        if (irq_soft && m_mie[3]) return 32'h8000_0003;
        return 32'h8000_0007;
    endfunction

    function automatic logic m_trap();
        return !m_pend && (exception || m_irq());
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
            12'hF14: return 32'd5;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_commit(input logic [31:0] p, input logic [31:0] c);
        m_mepc   = p & ~32'd3;
        m_mcause = c;
        m_mpie   = m_mie_b;
        m_mie_b  = 0;
    endtask

    // advance the model by one clock from the current inputs, then cross the edge
    task automatic tick();
        logic [31:0] o, n;
        if (!rst_n) begin
            m_mie_b = 0; m_mpie = 0; m_pend = 0; m_mie = 0; m_mtvec = 32'h1234;
            m_mepc = 0; m_mcause = 0; m_mscratch = 0; m_hpc = 0; m_hcause = 0;
        end else if (m_pend) begin
            if (!stall) begin
                m_commit(m_hpc, m_hcause);
                m_pend = 0;
            end
        end else if (exception || m_irq()) begin
            if (stall) begin
                m_pend = 1; m_hpc = pc; m_hcause = m_cause();
            end else m_commit(pc, m_cause());
        end else if (!stall && m_ret) begin
            m_mie_b = m_mpie;
            m_mpie  = 1;
        end else if (!stall && csr_we && csr_func3[1:0] != 2'b00) begin
            o = m_read(csr_addr);
            n = csr_func3[1:0] == 2'b01 ? csr_wdata : csr_func3[1:0] == 2'b10 ? (o | csr_wdata) : (o & ~csr_wdata);
            case (csr_addr)
                12'h300: begin m_mie_b = n[3]; m_mpie = n[7]; end
                12'h304: m_mie = n & 32'h888;
                12'h305: m_mtvec = n & ~32'd3;
                12'h340: m_mscratch = n;
                12'h341: m_mepc = n & ~32'd3;
                12'h342: m_mcause = n;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stall = 0; exception = 0; m_ret = 0; csr_we = 0; csr_func3 = 0; csr_wdata = 0;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [2:0] f, input logic [31:0] w);
        csr_we = 1; csr_addr = a; csr_func3 = f; csr_wdata = w;
        tick();
        csr_we = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; quiet();
        tick(); tick();
        rst_n = 1;
        @(negedge clk);
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h expected 0", mepc_o); end
        checks++; if (mtvec_o !== 32'h1234) begin errors++; $display("FAIL reset_mtvec_o: got %h expected 1234", mtvec_o); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus: got %h expected 1800", csr_rdata); end
        csr_addr = 12'h305; #1;
        checks++; if (csr_rdata !== 32'h1234) begin errors++; $display("FAIL reset_mtvec: got %h expected 1234", csr_rdata); end
        csr_addr = 12'hF14; #1;
        checks++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL reset_mhartid: got %h expected 5", csr_rdata); end
        tick();
    endtask

    task automatic test_exception();
        exception = 1; exception_cause = 31'd2; pc = 32'h100;
        @(negedge clk);
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL exc_trap: got %b expected 1", trap); end
        tick();
        exception = 0;
        @(negedge clk);
        checks++; if (mepc_o !== 32'h100) begin errors++; $display("FAIL exc_mepc: got %h expected 100", mepc_o); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h2) begin errors++; $display("FAIL exc_mcause: got %h expected 2", csr_rdata); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL exc_mstatus: got %h expected 1800", csr_rdata); end
        tick();
    endtask

    task automatic test_stall();
        exception = 1; exception_cause = 31'd5; pc = 32'h143; stall = 1;
        @(negedge clk);
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL stall_trap_c1: got %b expected 1", trap); end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL stall_trap_held: got %b expected 0", trap); end
            checks++; if (mepc_o !== 32'h100) begin errors++; $display("FAIL stall_mepc_held: got %h expected 100", mepc_o); end
            tick();
        end
        stall = 0; exception = 0;
        @(negedge clk);
        checks++; if (mepc_o !== 32'h100) begin errors++; $display("FAIL stall_mepc_pre: got %h expected 100", mepc_o); end
        tick();
        @(negedge clk);
        checks++; if (mepc_o !== 32'h140) begin errors++; $display("FAIL stall_mepc_commit: got %h expected 140", mepc_o); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h5) begin errors++; $display("FAIL stall_mcause: got %h expected 5", csr_rdata); end
        tick();
    endtask

    task automatic test_irq();
        csr_op(12'h300, 3'b001, 32'h8);
        csr_op(12'h304, 3'b001, 32'hFFFF_FFFF);
        irq_timer = 1; irq_ext = 1; pc = 32'h200;
        @(negedge clk);
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL irq_trap: got %b expected 1", trap); end
        tick();
        irq_ext = 0;
        @(negedge clk);
        checks++; if (mepc_o !== 32'h200) begin errors++; $display("FAIL irq_mepc: got %h expected 200", mepc_o); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause_ext: got %h expected 8000000b", csr_rdata); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL irq_no_retrap: got %b expected 0", trap); end
            tick();
            @(negedge clk);
        end
        m_ret = 1;
        #1;
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL irq_mret_trap: got %b expected 0", trap); end
        tick();
        m_ret = 0;
        @(negedge clk);
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL irq_timer_trap: got %b expected 1", trap); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL irq_mstatus_mret: got %h expected 1888", csr_rdata); end
        tick();
        irq_timer = 0;
        @(negedge clk);
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL irq_mcause_timer: got %h expected 80000007", csr_rdata); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL irq_mstatus_trap: got %h expected 1880", csr_rdata); end
        tick();
    endtask

    task automatic test_csr_ops();
        csr_op(12'h304, 3'b001, 32'h8);
        csr_we = 1; csr_addr = 12'h304; csr_func3 = 3'b010; csr_wdata = 32'h80;
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h8) begin errors++; $display("FAIL csrrs_old: got %h expected 8", csr_rdata); end
        tick();
        csr_func3 = 3'b011; csr_wdata = 32'h8;
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL csrrc_old: got %h expected 88", csr_rdata); end
        tick();
        csr_func3 = 3'b000; csr_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL csr_mie_final: got %h expected 80", csr_rdata); end
        tick();
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL csr_func3_0_nowrite: got %h expected 80", csr_rdata); end
        csr_we = 0;
        tick();
        csr_op(12'h305, 3'b101, 32'h1003);
        csr_op(12'h7C0, 3'b001, 32'h1234_5678);
        csr_op(12'hF14, 3'b001, 32'h77);
        @(negedge clk);
        csr_addr = 12'h305; #1;
        checks++; if (csr_rdata !== 32'h1000) begin errors++; $display("FAIL csr_mtvec_wr: got %h expected 1000", csr_rdata); end
        checks++; if (mtvec_o !== 32'h1000) begin errors++; $display("FAIL csr_mtvec_o: got %h expected 1000", mtvec_o); end
        csr_addr = 12'h7C0; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL csr_unimpl: got %h expected 0", csr_rdata); end
        csr_addr = 12'hF14; #1;
        checks++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL csr_hartid_ro: got %h expected 5", csr_rdata); end
        tick();
    endtask

    task automatic test_exc_vs_csr();
        exception = 1; exception_cause = 31'd4; pc = 32'h304;
        csr_we = 1; csr_addr = 12'h340; csr_func3 = 3'b001; csr_wdata = 32'hDEAD;
        @(negedge clk);
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL excw_trap: got %b expected 1", trap); end
        tick();
        quiet();
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL excw_mscratch: got %h expected 0", csr_rdata); end
        checks++; if (mepc_o !== 32'h304) begin errors++; $display("FAIL excw_mepc: got %h expected 304", mepc_o); end
        tick();
    endtask

    task automatic test_reset_pending();
        exception = 1; exception_cause = 31'd7; pc = 32'h500; stall = 1;
        tick();
        exception = 0;
        rst_n = 0;
        tick();
        rst_n = 1; stall = 0;
        @(negedge clk);
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL rstp_trap: got %b expected 0", trap); end
        tick();
        @(negedge clk);
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL rstp_discard: got %h expected 0", mepc_o); end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] al [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hF14, 12'h7C0};
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 59) != 0;
            stall = $urandom_range(0, 2) == 0;
            exception = $urandom_range(0, 7) == 0;
            exception_cause = 31'($urandom);
            pc = $urandom;
            m_ret = $urandom_range(0, 9) == 0;
            csr_we = $urandom_range(0, 1) == 1;
            csr_addr = al[$urandom_range(0, 8)];
            csr_func3 = 3'($urandom);
            csr_wdata = $urandom_range(0, 1) == 1 ? $urandom : 32'h888;
            irq_timer = $urandom_range(0, 3) == 0;
            irq_soft = $urandom_range(0, 3) == 0;
            irq_ext = $urandom_range(0, 3) == 0;
            @(negedge clk);
            checks++; if (trap !== m_trap()) begin errors++; $display("FAIL rnd_trap[%0d]: got %b expected %b", i, trap, m_trap()); end
            checks++; if (csr_rdata !== m_read(csr_addr)) begin errors++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", i, csr_addr, csr_rdata, m_read(csr_addr)); end
            checks++; if (mepc_o !== m_mepc) begin errors++; $display("FAIL rnd_mepc[%0d]: got %h expected %h", i, mepc_o, m_mepc); end
            checks++; if (mtvec_o !== m_mtvec) begin errors++; $display("FAIL rnd_mtvec[%0d]: got %h expected %h", i, mtvec_o, m_mtvec); end
            tick();
        end
        rst_n = 1; quiet(); irq_timer = 0; irq_soft = 0; irq_ext = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_exception();
        test_stall();
        test_irq();
        test_csr_ops();
        test_exc_vs_csr();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
